// File: rtl/i2c_master_arbiter.sv
// Purpose:      round-robin sharing of one I2C master between NUM_REQ on-chip requesters.
// Latency:      req seen in IDLE -> grant next cycle -> m_en one cycle later; done one cycle after m_done.
// Backpressure: GRANT holds while m_busy=1; losing requesters stay pending until served.
//
// Ports: clk/resetN (async active-low); req/req_rw/req_addr/req_wdata per requester (packed,
// requester 0 in LSBs); grant/done one-hot to the owner; rdata/nack/timeout_err response, valid
// with done and held until the next response; busy = not IDLE; m_* drive and observe the master.
// Optional macro I2C_ARB_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT_CYCLES; without it
// timeout_err is tied 0 and WAIT holds until m_done.
module i2c_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 7,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_rw,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      nack,
  output logic                      timeout_err,
  output logic                      busy,
  output logic                      m_en,
  output logic                      m_rw,
  output logic [ADDR_W-1:0]         m_addr,
  output logic [DATA_W-1:0]         m_wdata,
  input  logic                      m_busy,
  input  logic                      m_done,
  input  logic                      m_nack,
  input  logic [DATA_W-1:0]         m_rdata
);

  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t              state, state_nxt;
  logic [PW-1:0]       ptr, win, pick;
  logic                pick_vld;
  logic                pick_rw;
  logic [ADDR_W-1:0]   pick_addr;
  logic [DATA_W-1:0]   pick_wdata;
  logic [NUM_REQ-1:0]  win_oh;
  logic                rsp_cap;
  logic                wd_fire;
  int                  idx;
  logic [PW-1:0]       idx_w;

  // Scan from ptr upward with wrap; iterating the offsets from highest to lowest lets the
  // nearest set bit overwrite the others.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    idx_w    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_w = PW'(idx);
      if (req[idx_w]) begin
        pick     = idx_w;
        pick_vld = 1'b1;
      end
    end
  end

  // Command mux and owner decode use constant slices only.
  always_comb begin
    pick_rw    = 1'b0;
    pick_addr  = '0;
    pick_wdata = '0;
    win_oh     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == PW'(i)) begin
        pick_rw    = req_rw[i];
        pick_addr  = req_addr[i*ADDR_W +: ADDR_W];
        pick_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
      win_oh[i] = (win == PW'(i));
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_cnt;
  logic          wd_exp;
  assign wd_exp = (wd_cnt >= WW'(TIMEOUT_CYCLES));
`else
  logic          wd_exp;
  assign wd_exp = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rsp_cap   = 1'b0;
    wd_fire   = 1'b0;
    case (state)
      S_IDLE:   if (pick_vld) state_nxt = S_GRANT;
      S_GRANT:  if (!m_busy) state_nxt = S_LAUNCH;
      // A completion arriving in the launch cycle itself is accepted.
      S_LAUNCH: begin
        if (m_done) begin
          state_nxt = S_RESP;
          rsp_cap   = 1'b1;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (m_done) begin
          state_nxt = S_RESP;
          rsp_cap   = 1'b1;
        end else if (wd_exp) begin
          state_nxt = S_RESP;
          wd_fire   = 1'b1;
        end
      end
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign busy  = (state != S_IDLE);
  assign grant = busy ? win_oh : '0;
  assign done  = (state == S_RESP) ? win_oh : '0;
  assign m_en  = (state == S_LAUNCH);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ptr     <= '0;
      win     <= '0;
      m_rw    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      rdata   <= '0;
      nack    <= 1'b0;
    end else begin
      if (state == S_IDLE && pick_vld) begin
        win     <= pick;
        m_rw    <= pick_rw;
        m_addr  <= pick_addr;
        m_wdata <= pick_wdata;
      end
      if (rsp_cap) begin
        rdata <= m_rdata;
        nack  <= m_nack;
      end else if (wd_fire) begin
        rdata <= '0;
        nack  <= 1'b1;
      end
      if (state == S_RESP) ptr <= (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  // Counter restarts on every entry to WAIT (it is cleared during LAUNCH).
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == S_LAUNCH)    wd_cnt <= '0;
      else if (state == S_WAIT) wd_cnt <= wd_cnt + WW'(1);
      if (rsp_cap)      timeout_err <= 1'b0;
      else if (wd_fire) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter: the I2C master is played by the stimulus tasks.
module tb_i2c_master_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;

  logic                      clk = 1'b0;
  logic                      resetN;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_rw;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        grant, done;
  logic [DATA_W-1:0]         rdata;
  logic                      nack, timeout_err, busy;
  logic                      m_en, m_rw;
  logic [ADDR_W-1:0]         m_addr;
  logic [DATA_W-1:0]         m_wdata;
  logic                      m_busy, m_done, m_nack;
  logic [DATA_W-1:0]         m_rdata;

  int n_chk  = 0;
  int n_fail = 0;
  int en_cnt = 0;

  i2c_master_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .resetN(resetN), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .grant(grant), .done(done), .rdata(rdata), .nack(nack),
    .timeout_err(timeout_err), .busy(busy), .m_en(m_en), .m_rw(m_rw), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_busy(m_busy), .m_done(m_done), .m_nack(m_nack), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (m_en) en_cnt++;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_cmd(input int i, input logic rw, input logic [6:0] a, input logic [7:0] d);
    req_rw[i]              = rw;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  // Called at the LAUNCH negedge: waits 'dly' cycles, pulses m_done, returns at the RESP negedge.
  task automatic finish_master(input int dly, input logic nk, input logic [7:0] rd);
    repeat (dly) tick();
    m_done = 1'b1; m_nack = nk; m_rdata = rd;
    tick();
    m_done = 1'b0; m_nack = 1'b0;
  endtask

  task automatic test_reset();
    resetN = 1'b0; req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    m_busy = 1'b0; m_done = 1'b0; m_nack = 1'b0; m_rdata = '0;
    tick(); tick();
    n_chk++; if ({grant, done, busy, m_en} !== 10'b0) begin n_fail++;
      $display("FAIL reset_ctrl: got grant=%b done=%b busy=%b m_en=%b want all 0", grant, done, busy, m_en); end
    n_chk++; if ({m_rw, m_addr, m_wdata} !== 16'h0) begin n_fail++;
      $display("FAIL reset_cmd: got rw=%b addr=%h wdata=%h want 0", m_rw, m_addr, m_wdata); end
    n_chk++; if ({rdata, nack, timeout_err} !== 10'h0) begin n_fail++;
      $display("FAIL reset_rsp: got rdata=%h nack=%b terr=%b want 0", rdata, nack, timeout_err); end
    resetN = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    int e0;
    e0 = en_cnt;
    set_cmd(1, 1'b0, 7'h50, 8'hA5);
    req = 4'b0010;
    tick();
    n_chk++; if (grant !== 4'b0010 || m_en !== 1'b0) begin n_fail++;
      $display("FAIL wr_grant: got grant=%b m_en=%b want 0010/0", grant, m_en); end
    tick();
    n_chk++; if (m_en !== 1'b1 || m_addr !== 7'h50 || m_wdata !== 8'hA5 || m_rw !== 1'b0) begin n_fail++;
      $display("FAIL wr_launch: got en=%b addr=%h wdata=%h rw=%b want 1/50/a5/0", m_en, m_addr, m_wdata, m_rw); end
    finish_master(10, 1'b0, 8'hFF);
    n_chk++; if (done !== 4'b0010 || nack !== 1'b0 || timeout_err !== 1'b0) begin n_fail++;
      $display("FAIL wr_done: got done=%b nack=%b terr=%b want 0010/0/0", done, nack, timeout_err); end
    req = '0;
    tick();
    n_chk++; if (en_cnt - e0 !== 1 || done !== 4'b0 || grant !== 4'b0) begin n_fail++;
      $display("FAIL wr_after: got pulses=%0d done=%b grant=%b want 1/0000/0000", en_cnt - e0, done, grant); end
  endtask

  task automatic test_read();
    set_cmd(2, 1'b1, 7'h21, 8'h00);
    req = 4'b0100;
    tick();
    n_chk++; if (grant !== 4'b0100) begin n_fail++;
      $display("FAIL rd_grant: got %b want 0100", grant); end
    req = '0;  // dropping req after grant must not abort
    tick();
    n_chk++; if (m_en !== 1'b1 || m_rw !== 1'b1 || m_addr !== 7'h21) begin n_fail++;
      $display("FAIL rd_launch: got en=%b rw=%b addr=%h want 1/1/21", m_en, m_rw, m_addr); end
    finish_master(3, 1'b0, 8'h3C);
    n_chk++; if (done !== 4'b0100 || rdata !== 8'h3C) begin n_fail++;
      $display("FAIL rd_done: got done=%b rdata=%h want 0100/3c", done, rdata); end
    m_rdata = 8'h00;
    tick(); tick();
    n_chk++; if (done !== 4'b0 || rdata !== 8'h3C || busy !== 1'b0) begin n_fail++;
      $display("FAIL rd_hold: got done=%b rdata=%h busy=%b want 0000/3c/0", done, rdata, busy); end
  endtask

  task automatic test_contention();
    logic [3:0] exp;
    resetN = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_cmd(i, 1'b0, 7'h10 + 7'(i), 8'h00);
    req = 4'b1111;
    tick();
    resetN = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp = 4'b0001 << (k % 4);
      tick();
      n_chk++; if (grant !== exp || !$onehot(grant)) begin n_fail++;
        $display("FAIL cont_grant%0d: got %b want %b", k, grant, exp); end
      tick();
      n_chk++; if (m_en !== 1'b1 || m_addr !== 7'h10 + 7'(k % 4)) begin n_fail++;
        $display("FAIL cont_cmd%0d: got en=%b addr=%h want 1/%h", k, m_en, m_addr, 7'h10 + 7'(k % 4)); end
      finish_master(2, 1'b0, 8'h00);
      n_chk++; if (done !== exp || grant !== exp) begin n_fail++;
        $display("FAIL cont_done%0d: got done=%b grant=%b want %b", k, done, grant, exp); end
      tick();
      n_chk++; if (grant !== 4'b0 || busy !== 1'b0) begin n_fail++;
        $display("FAIL cont_idle%0d: got grant=%b busy=%b want 0000/0", k, grant, busy); end
    end
    req = '0;
    tick();
  endtask

  task automatic test_nack_busy();
    set_cmd(3, 1'b0, 7'h33, 8'h5A);
    req = 4'b1000; m_busy = 1'b1;
    tick();
    n_chk++; if (grant !== 4'b1000) begin n_fail++;
      $display("FAIL nb_grant: got %b want 1000", grant); end
    for (int k = 0; k < 5; k++) begin
      n_chk++; if (m_en !== 1'b0 || grant !== 4'b1000) begin n_fail++;
        $display("FAIL nb_hold%0d: got en=%b grant=%b want 0/1000", k, m_en, grant); end
      tick();
    end
    m_busy = 1'b0;
    n_chk++; if (m_en !== 1'b0) begin n_fail++;
      $display("FAIL nb_late: got en=%b want 0", m_en); end
    tick();
    n_chk++; if (m_en !== 1'b1) begin n_fail++;
      $display("FAIL nb_launch: got en=%b want 1", m_en); end
    finish_master(4, 1'b1, 8'h00);
    n_chk++; if (done !== 4'b1000 || nack !== 1'b1) begin n_fail++;
      $display("FAIL nb_done: got done=%b nack=%b want 1000/1", done, nack); end
    req = '0;
    tick();
  endtask

  task automatic test_spurious();
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    n_chk++; if (done !== 4'b0 || busy !== 1'b0) begin n_fail++;
      $display("FAIL spur: got done=%b busy=%b want 0000/0", done, busy); end
  endtask

  task automatic test_reset_mid();
    // Serve requester 2 so the pointer moves to 3 before the abort.
    set_cmd(2, 1'b0, 7'h22, 8'h00);
    req = 4'b0100;
    tick(); tick();
    finish_master(1, 1'b0, 8'h11);
    req = '0;
    tick();
    set_cmd(1, 1'b0, 7'h41, 8'h00);
    req = 4'b0010;
    tick(); tick(); tick(); tick();
    resetN = 1'b0;
    #1;
    n_chk++; if ({grant, done, busy, m_en, m_addr, rdata, nack} !== 26'h0) begin n_fail++;
      $display("FAIL rst_mid: got grant=%b done=%b busy=%b en=%b addr=%h rdata=%h nack=%b want 0",
               grant, done, busy, m_en, m_addr, rdata, nack); end
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    n_chk++; if (done !== 4'b0 || busy !== 1'b0) begin n_fail++;
      $display("FAIL rst_nodone: got done=%b busy=%b want 0000/0", done, busy); end
    set_cmd(0, 1'b0, 7'h0A, 8'h00);
    set_cmd(3, 1'b0, 7'h3B, 8'h00);
    req = 4'b1001;
    resetN = 1'b1;
    tick();
    n_chk++; if (grant !== 4'b0001) begin n_fail++;
      $display("FAIL rst_ptr: got %b want 0001", grant); end
    tick();
    finish_master(0, 1'b0, 8'h00);
    n_chk++; if (done !== 4'b0001 || m_addr !== 7'h0A) begin n_fail++;
      $display("FAIL rst_serve: got done=%b addr=%h want 0001/0a", done, m_addr); end
    req = '0;
    tick(); tick();
  endtask

`ifdef I2C_ARB_TIMEOUT_EN
  task automatic test_watchdog();
    set_cmd(0, 1'b1, 7'h0C, 8'h00);
    req = 4'b0001;
    tick(); tick();
    tick();  // first WAIT cycle
    for (int k = 1; k <= 16; k++) begin
      tick();
      n_chk++; if (done !== 4'b0) begin n_fail++;
        $display("FAIL wd_early%0d: got done=%b want 0000", k, done); end
    end
    tick();
    n_chk++; if (done !== 4'b0001 || timeout_err !== 1'b1 || nack !== 1'b1 || rdata !== 8'h00) begin n_fail++;
      $display("FAIL wd_fire: got done=%b terr=%b nack=%b rdata=%h want 0001/1/1/00", done, timeout_err, nack, rdata); end
    req = '0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_read();
    test_contention();
    test_nack_busy();
    test_spurious();
    test_reset_mid();
`ifdef I2C_ARB_TIMEOUT_EN
    test_watchdog();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
